ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xF4 mouse enable, 0xFF reset) to a keyboard or mouse over the shared open-drain ps2c/ps2d lines.
- Runs the inhibit / request-to-send sequence, shifts 8 data bits plus odd parity on device-generated clock edges, then checks the device acknowledge bit.
- Sits beside the PS/2 receive path. tx_idle gates that receiver so it ignores line activity caused by host transmission.

Parameters:
INHIBIT_CYCLES, 12000, clk cycles ps2c is held low for request-to-send (120 us at 100 MHz)
FILTER_LEN, 8, consecutive equal ps2c samples required to change the filtered clock value
TIMEOUT_CYCLES, 2000000, clk cycles without a filtered ps2c falling edge before abort (20 ms at 100 MHz)

Ports:
clk  in  1  system clock; sole clock domain
reset  in  1  asynchronous, active-low reset
wr_ps2  in  1  one-cycle strobe: start transmitting din
din  in  8  command byte, sampled on the wr_ps2 cycle
ps2c  inout  1  PS/2 clock; driven 0 or released (Z), never driven 1
ps2d  inout  1  PS/2 data; driven 0 or released (Z), never driven 1
tx_idle  out  1  1 when in IDLE
tx_done_tick  out  1  one-cycle pulse at the end of every transfer, normal or aborted
ack_err  out  1  1 if the device did not pull ps2d low in the ack slot; valid from tx_done_tick until next accepted wr_ps2
to_err  out  1  1 if the last transfer aborted on timeout; same validity as ack_err

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, both lines released, tx_idle=1, tx_done_tick=0, ack_err=0, to_err=0, filter and edge history = 1.
- Filter: ps2c is sampled each clk into a FILTER_LEN shift register. filt_c goes to 1 on all-ones and to 0 on all-zeros; otherwise it holds. fall = previous filt_c AND NOT filt_c. ps2d is read raw.
- Shift register b[8:0] = {~^din, din} (odd parity) is loaded on an accepted wr_ps2. Bit counter n is 4 bits.
- IDLE: lines released. wr_ps2=1 loads b, clears ack_err and to_err, loads the counter with INHIBIT_CYCLES-1, and moves to RTS.
- RTS: drive ps2c=0, release ps2d. Counter decrements each cycle; at 0 go to START. fall is ignored here.
- START: release ps2c, drive ps2d=0 (start bit). Timeout counter runs. On fall: n=8, go to DATA.
- DATA: ps2d driven 0 when b[0]=0, released when b[0]=1. On fall: if n==0 go to STOP, else shift b right and decrement n. Result: d0..d7 then parity, one bit per fall.
- STOP: release ps2d (stop bit = 1 via pull-up). On fall go to ACK.
- ACK: on fall, set ack_err = ps2d, pulse tx_done_tick, go to IDLE.
- Timeout: in START, DATA, STOP and ACK a counter reloads on every fall and on state entry. If it reaches TIMEOUT_CYCLES, release both lines, set to_err=1 and ack_err=0, pulse tx_done_tick, go to IDLE.
- wr_ps2 outside IDLE is ignored. din is don't-care except on the accepted cycle.
- tx_idle is 0 from the cycle after an accepted wr_ps2 until the cycle tx_done_tick is asserted, inclusive of that cycle. It is 1 again the following cycle.
- Back-to-back: a wr_ps2 in the first IDLE cycle after tx_done_tick is accepted.
- Reset mid-transfer: both lines are released immediately (asynchronously) and no tx_done_tick is generated.
- Latency: wr_ps2 → ps2c driven low is 1 cycle. RTS duration is exactly INHIBIT_CYCLES cycles.

Test Plan:
- INHIBIT_CYCLES=100, device model with 80-cycle clock period; wr_ps2, din=0xF4 → ps2c low for exactly 100 cycles; model captures start=0, bits 0,0,1,0,1,1,1,1, parity 0, stop=1; model acks → tx_done_tick, ack_err=0, to_err=0.
- din=0xFF → parity captured as 1; model withholds ack (ps2d high in ack slot) → ack_err=1 at tx_done_tick; it clears on the next accepted wr_ps2.
- TIMEOUT_CYCLES=5000, device never clocks after RTS → tx_done_tick at 5000 cycles after START entry, to_err=1, both lines released.
- Glitch: 3-cycle low pulses on ps2c during DATA with FILTER_LEN=8 → no bit advance; the transmitted byte (0xA5, parity 1) is captured intact.
- wr_ps2 pulsed repeatedly mid-transfer with din=0x00 → ignored; 0xED is transmitted, then a wr_ps2 in the first IDLE cycle after done is accepted.
- reset=0 asserted during DATA → ps2c and ps2d go Z within the same cycle, tx_idle=1, no tx_done_tick.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibit/request-to-send, 8 data bits plus odd parity on device clock falls, ack check, timeout abort.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err,
  output logic       to_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP,
    ACK
  } state_t;

  state_t                state;
  logic [FILTER_LEN-1:0] c_sr;
  logic                  filt_c;
  logic                  filt_c_q;
  logic                  fall;
  logic [8:0]            b;
  logic [3:0]            n;
  logic [IW-1:0]         inh_cnt;
  logic [TW-1:0]         to_cnt;
  logic                  c_low;
  logic                  d_low;

  // Open-drain: only ever pull low, the external pull-ups supply the high level.
  assign ps2c = c_low ? 1'b0 : 1'bz;
  assign ps2d = d_low ? 1'b0 : 1'bz;

  assign fall = filt_c_q & ~filt_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sr     <= '1;
      filt_c   <= 1'b1;
      filt_c_q <= 1'b1;
    end else begin
      c_sr     <= {c_sr[FILTER_LEN-2:0], ps2c};
      if (&c_sr) begin
        filt_c <= 1'b1;
      end else if (~|c_sr) begin
        filt_c <= 1'b0;
      end
      filt_c_q <= filt_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      c_low        <= 1'b0;
      d_low        <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      ack_err      <= 1'b0;
      to_err       <= 1'b0;
      b            <= '0;
      n            <= '0;
      inh_cnt      <= '0;
      to_cnt       <= '0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          c_low   <= 1'b0;
          d_low   <= 1'b0;
          tx_idle <= 1'b1;
          if (wr_ps2) begin
            b       <= {~^din, din};
            ack_err <= 1'b0;
            to_err  <= 1'b0;
            inh_cnt <= IW'(INHIBIT_CYCLES - 1);
            c_low   <= 1'b1;
            tx_idle <= 1'b0;
            state   <= RTS;
          end
        end
        RTS: begin
          if (inh_cnt == '0) begin
            c_low  <= 1'b0;
            d_low  <= 1'b1;
            to_cnt <= '0;
            state  <= START;
          end else begin
            inh_cnt <= inh_cnt - 1'b1;
          end
        end
        START, DATA, STOP, ACK: begin
          to_cnt <= to_cnt + 1'b1;
          // A device clock edge wins over a timeout landing on the same cycle.
          if (fall) begin
            to_cnt <= '0;
            case (state)
              START: begin
                n     <= 4'd8;
                d_low <= ~b[0];
                state <= DATA;
              end
              DATA: begin
                if (n == 4'd0) begin
                  d_low <= 1'b0;
                  state <= STOP;
                end else begin
                  b     <= {1'b0, b[8:1]};
                  n     <= n - 4'd1;
                  d_low <= ~b[1];
                end
              end
              STOP: begin
                state <= ACK;
              end
              default: begin
                ack_err      <= ps2d;
                tx_done_tick <= 1'b1;
                state        <= IDLE;
              end
            endcase
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            c_low        <= 1'b0;
            d_low        <= 1'b0;
            to_err       <= 1'b1;
            ack_err      <= 1'b0;
            tx_done_tick <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          c_low <= 1'b0;
          d_low <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx
// Behavioural PS/2 device drives the clock, captures frames and acks; frames checked against a parity model.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int FLT  = 8;
  localparam int TMO  = 5000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  wire        ps2c;
  wire        ps2d;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;
  logic       to_err;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .ack_err     (ack_err),
    .to_err      (to_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Done-tick monitor: records what the outputs looked like on each tick and one cycle later.
  int   cyc = 0;
  int   tick_cnt = 0;
  int   tick_time = 0;
  logic tick_ack = 1'b0;
  logic tick_to = 1'b0;
  logic tick_idle = 1'b1;
  logic idle_after = 1'b0;
  logic prev_tick = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (prev_tick) idle_after = tx_idle;
    prev_tick = tx_done_tick;
    if (tx_done_tick) begin
      tick_cnt++;
      tick_time = cyc;
      tick_ack  = ack_err;
      tick_to   = to_err;
      tick_idle = tx_idle;
    end
  end

  // Frame as the device should see it: {stop, parity, d7..d0, start}.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int   ones;
    logic par;
    ones = $countones(d);
    par  = (ones % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // Device side of one transfer: measure inhibit, read start bit, then 12 clock pulses.
  task automatic dev_xfer(input bit ack, input bit glitch, output logic [10:0] cap, output int lowcnt);
    cap    = '1;
    lowcnt = 0;
    while (ps2c === 1'b0 && lowcnt < 20000) begin
      lowcnt++;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    cap[0] = ps2d;
    for (int k = 1; k <= 12; k++) begin
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c_low = 1'b0;
      if (k <= 10) cap[k] = ps2d;
      if (k == 11 && ack) dev_d_low = 1'b1;
      if (k == 12) dev_d_low = 1'b0;
      if (k < 12) begin
        if (glitch && k <= 8) begin
          repeat (10) @(negedge clk);
          dev_c_low = 1'b1;
          repeat (3) @(negedge clk);
          dev_c_low = 1'b0;
          repeat (HALF - 13) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input bit glitch,
                          input bit exp_par, input bit exp_ack_err, input string tag);
    logic [10:0] cap;
    int          lc;
    int          tc0;
    tc0 = tick_cnt;
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'($urandom);
    check({tag, " accept c/idle/ack/to"}, {28'd0, ps2c, tx_idle, ack_err, to_err}, 32'h0);
    dev_xfer(ack, glitch, cap, lc);
    repeat (3) @(negedge clk);
    check({tag, " rts_len"}, lc, INH);
    check({tag, " frame"}, {21'd0, cap}, {21'd0, model_frame(d)});
    check({tag, " parity"}, {31'd0, cap[9]}, {31'd0, exp_par});
    check({tag, " ticks"}, tick_cnt - tc0, 1);
    check({tag, " ack_err"}, {31'd0, tick_ack}, {31'd0, exp_ack_err});
    check({tag, " to_err"}, {31'd0, tick_to}, 32'd0);
    check({tag, " idle tick/after"}, {30'd0, tick_idle, idle_after}, 32'h1);
    check({tag, " lines"}, {30'd0, ps2c, ps2d}, 32'h3);
  endtask

  typedef struct {
    logic [7:0] din;
    bit         ack;
    bit         glitch;
    bit         exp_par;
    bit         exp_ack_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [10:0] cap;
    logic [10:0] cap2;
    int          lc;
    int          lc2;
    int          t;
    int          tc0;
    int          start_cyc;
    logic [7:0]  rd;
    bit          ra;
    bit          rg;

    vecs[0] = '{8'hF4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset idle/done/ack/to", {28'd0, tx_idle, tx_done_tick, ack_err, to_err}, 32'h8);
    check("reset lines", {30'd0, ps2c, ps2d}, 32'h3);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_xfer(vecs[i].din, vecs[i].ack, vecs[i].glitch, vecs[i].exp_par, vecs[i].exp_ack_err,
               $sformatf("vec%0d", i));
    end

    // Device never clocks: abort TMO cycles after START entry.
    tc0 = tick_cnt;
    @(negedge clk);
    din    = 8'h5A;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    t = 0;
    while (ps2c === 1'b0 && t < 1000) begin
      t++;
      @(negedge clk);
    end
    start_cyc = cyc;
    check("timeout rts_len", t, INH);
    t = 0;
    while (tick_cnt == tc0 && t < TMO + 500) begin
      t++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("timeout ticks", tick_cnt - tc0, 1);
    check("timeout latency", tick_time - start_cyc, TMO);
    check("timeout to/ack", {30'd0, tick_to, tick_ack}, 32'h2);
    check("timeout lines", {30'd0, ps2c, ps2d}, 32'h3);
    check("timeout to_err held", {31'd0, to_err}, 32'h1);

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      rg = 1'($urandom_range(0, 1));
      run_xfer(rd, ra, rg, model_frame(rd)[9], !ra, $sformatf("rnd%0d", i));
    end

    // Strobes during a transfer are ignored; a strobe right after done is accepted.
    tc0 = tick_cnt;
    @(negedge clk);
    din    = 8'hED;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    fork
      begin
        dev_xfer(1'b1, 1'b0, cap, lc);
        dev_xfer(1'b1, 1'b0, cap2, lc2);
      end
      begin
        repeat (50) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          din    = 8'h00;
          wr_ps2 = 1'b1;
          @(negedge clk);
          wr_ps2 = 1'b0;
          repeat (150) @(negedge clk);
        end
        t = 0;
        while (tx_done_tick !== 1'b1 && t < 5000) begin
          t++;
          @(negedge clk);
        end
        check("b2b first done seen", {31'd0, tx_done_tick}, 32'h1);
        @(negedge clk);
        check("b2b idle before strobe", {31'd0, tx_idle}, 32'h1);
        din    = 8'h3C;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        check("b2b accept c/idle", {30'd0, ps2c, tx_idle}, 32'h0);
      end
    join
    repeat (3) @(negedge clk);
    check("ignored rts_len", lc, INH);
    check("ignored frame ED", {21'd0, cap}, {21'd0, model_frame(8'hED)});
    check("ignored parity ED", {31'd0, cap[9]}, 32'h1);
    check("b2b frame 3C", {21'd0, cap2}, {21'd0, model_frame(8'h3C)});
    check("b2b ticks", tick_cnt - tc0, 2);

    // Reset during RTS releases ps2c at once.
    tc0 = tick_cnt;
    @(negedge clk);
    din    = 8'h11;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    repeat (10) @(negedge clk);
    check("rts pre-reset ps2c", {31'd0, ps2c}, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rts reset c/d/idle/done", {28'd0, ps2c, ps2d, tx_idle, tx_done_tick}, 32'hE);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Reset during DATA releases ps2d at once and produces no done tick.
    @(negedge clk);
    din    = 8'h00;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    t = 0;
    while (ps2c === 1'b0 && t < 1000) begin
      t++;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    check("data pre-reset ps2d", {31'd0, ps2d}, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("data reset c/d/idle/done", {28'd0, ps2c, ps2d, tx_idle, tx_done_tick}, 32'hE);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("reset no tick", tick_cnt - tc0, 0);
    check("post-reset idle/ack/to", {29'd0, tx_idle, ack_err, to_err}, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
